seq_detect_param: RTL and testbench

//  Parametrised serial bit-sequence detector, successor to the fixed 1010 Mealy detectors.
//  - Samples 1 bit/clk when en=1.
//  - Flags a match of a runtime-loadable SEQ_LEN-bit pattern, in overlapping or non-overlapping mode.
//  - Provides a Mealy (same-cycle) and a registered match pulse, plus a saturating match counter.
//  - Sits on serial data paths; feeds protocol framers and status registers.

---
 rtl/seq_detect_param.sv | 110 +++++++++++
 tb/tb_seq_detect_param.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// ---------------------------------------------------------------------------
// seq_detect_param
//   Serial bit-sequence detector with a runtime-loadable SEQ_LEN-bit pattern.
//   One bit is sampled per clock while en is high. Matches may overlap
//   (suffix of one match starts the next) or not (next match needs SEQ_LEN
//   fresh bits). Provides a same-cycle Mealy match, a registered copy of it,
//   and a saturating match counter.
//
// Ports
//   clk        in   1        rising-edge clock
//   reset      in   1        asynchronous reset, active low
//   en         in   1        sample a this cycle
//   a          in   1        serial data bit
//   cfg_load   in   1        load pat_in/ovl_in (priority over en, bit discarded)
//   pat_in     in   SEQ_LEN  new pattern, MSB is the first bit received
//   ovl_in     in   1        new overlap mode (1 = overlapping)
//   cnt_clr    in   1        synchronous clear of match_cnt (wins over a hit)
//   c          out  1        Mealy match, combinational from state and a
//   c_q        out  1        c delayed by one clock
//   match_cnt  out  CNT_W    saturating match count
//   cnt_sat    out  1        match_cnt is all ones
// ---------------------------------------------------------------------------
module seq_detect_param #(
   parameter int unsigned        SEQ_LEN     = 4,
   parameter logic [SEQ_LEN-1:0] PAT_DEFAULT = 4'b1010,
   parameter logic               OVERLAP_DEF = 1'b1,
   parameter int unsigned        CNT_W       = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic               a,
   input  logic               cfg_load,
   input  logic [SEQ_LEN-1:0] pat_in,
   input  logic               ovl_in,
   input  logic               cnt_clr,
   output logic               c,
   output logic               c_q,
   output logic [CNT_W-1:0]   match_cnt,
   output logic               cnt_sat
);

   localparam int unsigned       FILL_W    = $clog2(SEQ_LEN);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SEQ_LEN - 1);

   logic [SEQ_LEN-2:0] r_hist;   // r_hist[0] is the newest bit
   logic [FILL_W-1:0]  r_fill;   // valid bits held in r_hist
   logic [SEQ_LEN-1:0] r_pat;
   logic               r_ovl;
   logic               r_cq;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_sat;

   logic [SEQ_LEN-1:0] w_window;
   logic               w_hit;
   logic [CNT_W-1:0]   w_cnt_nxt;

   // Window is the history plus the bit on the wire now; its low SEQ_LEN-1
   // bits are also the shifted history, which keeps SEQ_LEN=2 legal.
   assign w_window = {r_hist, a};
   assign w_hit    = en & ~cfg_load & (r_fill == FILL_FULL) & (w_window == r_pat);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_hist <= '0;
         r_fill <= '0;
         r_pat  <= PAT_DEFAULT;
         r_ovl  <= OVERLAP_DEF;
      end else if (cfg_load) begin
         r_pat  <= pat_in;
         r_ovl  <= ovl_in;
         r_fill <= '0;
      end else if (en) begin
         r_hist <= w_window[SEQ_LEN-2:0];
         // Non-overlap restarts filling after a hit; overlap keeps the window full.
         if (w_hit && !r_ovl) begin
            r_fill <= '0;
         end else if (r_fill != FILL_FULL) begin
            r_fill <= r_fill + 1'b1;
         end
      end
   end

   always_comb begin
      w_cnt_nxt = r_cnt;
      if (cnt_clr) begin
         w_cnt_nxt = '0;
      end else if (w_hit && (r_cnt != '1)) begin
         w_cnt_nxt = r_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cq  <= 1'b0;
         r_cnt <= '0;
         r_sat <= 1'b0;
      end else begin
         r_cq  <= w_hit;
         r_cnt <= w_cnt_nxt;
         r_sat <= (w_cnt_nxt == '1);
      end
   end

   assign c         = w_hit;
   assign c_q       = r_cq;
   assign match_cnt = r_cnt;
   assign cnt_sat   = r_sat;

endmodule

// File: tb/tb_seq_detect_param.sv
// ---------------------------------------------------------------------------
// tb_seq_detect_param
//   Two detector instances share all inputs: one with the default 8-bit
//   counter, one with a 2-bit counter so saturation is reachable quickly.
//   Expected values come from a queue-based model of the received bit stream.
// ---------------------------------------------------------------------------
module tb_seq_detect_param;

   localparam int SL = 4;

   logic          clk      = 1'b0;
   logic          reset    = 1'b1;
   logic          en       = 1'b0;
   logic          a        = 1'b0;
   logic          cfg_load = 1'b0;
   logic [SL-1:0] pat_in   = '0;
   logic          ovl_in   = 1'b0;
   logic          cnt_clr  = 1'b0;

   logic       c, c_q, cnt_sat;
   logic [7:0] match_cnt;
   logic       c2, c_q2, cnt_sat2;
   logic [1:0] match_cnt2;

   seq_detect_param dut (
      .clk(clk), .reset(reset), .en(en), .a(a), .cfg_load(cfg_load),
      .pat_in(pat_in), .ovl_in(ovl_in), .cnt_clr(cnt_clr),
      .c(c), .c_q(c_q), .match_cnt(match_cnt), .cnt_sat(cnt_sat)
   );

   seq_detect_param #(.CNT_W(2)) dut2 (
      .clk(clk), .reset(reset), .en(en), .a(a), .cfg_load(cfg_load),
      .pat_in(pat_in), .ovl_in(ovl_in), .cnt_clr(cnt_clr),
      .c(c2), .c_q(c_q2), .match_cnt(match_cnt2), .cnt_sat(cnt_sat2)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: bits received since the last restart point
   bit          q[$];
   logic [SL-1:0] m_pat = 4'b1010;
   bit          m_ovl   = 1'b1;
   int          m_cnt8  = 0;
   int          m_cnt2  = 0;
   bit          m_cq    = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic bit model_hit(input logic e, input logic x, input logic ld);
      int n;
      logic [SL-1:0] w;
      n = q.size();
      if (!e || ld || n < SL - 1) return 1'b0;
      w = '0;
      for (int i = SL - 1; i >= 1; i--) w = {w[SL-2:0], q[n-i]};
      w = {w[SL-2:0], x};
      return w == m_pat;
   endfunction

   task automatic model_reset();
      q.delete();
      m_pat  = 4'b1010;
      m_ovl  = 1'b1;
      m_cnt8 = 0;
      m_cnt2 = 0;
      m_cq   = 1'b0;
   endtask

   task automatic chk_regs(input string tag);
      chk({tag, "_cq"},   c_q,        m_cq);
      chk({tag, "_cnt"},  match_cnt,  m_cnt8);
      chk({tag, "_sat"},  cnt_sat,    m_cnt8 == 255);
      chk({tag, "_cq2"},  c_q2,       m_cq);
      chk({tag, "_cnt2"}, match_cnt2, m_cnt2);
      chk({tag, "_sat2"}, cnt_sat2,   m_cnt2 == 3);
   endtask

   // One clock: drive inputs, check Mealy output, clock, update model, check registers.
   task automatic cycle(input logic i_en, input logic i_a, input logic i_load,
                        input logic [SL-1:0] i_pat, input logic i_ovl, input logic i_clr);
      bit e_hit;
      en = i_en; a = i_a; cfg_load = i_load; pat_in = i_pat; ovl_in = i_ovl; cnt_clr = i_clr;
      #1;
      e_hit = model_hit(i_en, i_a, i_load);
      chk("c",  c,  e_hit);
      chk("c2", c2, e_hit);
      @(posedge clk);
      #1;
      if (i_load) begin
         m_pat = i_pat;
         m_ovl = i_ovl;
         q.delete();
      end else if (i_en) begin
         q.push_back(i_a);
         if (q.size() > SL) void'(q.pop_front());
         if (e_hit && !m_ovl) q.delete();
      end
      if (i_clr) begin
         m_cnt8 = 0;
         m_cnt2 = 0;
      end else if (e_hit) begin
         if (m_cnt8 < 255) m_cnt8++;
         if (m_cnt2 < 3)   m_cnt2++;
      end
      m_cq = e_hit;
      chk_regs("reg");
   endtask

   task automatic bit_in(input logic x);
      cycle(1'b1, x, 1'b0, '0, 1'b0, 1'b0);
   endtask

   // Assert reset mid-cycle, check outputs clear at once, hold with a toggling.
   task automatic apply_reset(input int cycles);
      reset = 1'b0;
      #1;
      model_reset();
      chk("rst_c",  c,  0);
      chk("rst_c2", c2, 0);
      chk_regs("rst");
      for (int i = 0; i < cycles; i++) begin
         en = 1'b1; a = ~a; cfg_load = 1'b0; cnt_clr = 1'b0;
         #1;
         chk("rst_hold_c",  c,  0);
         chk("rst_hold_c2", c2, 0);
         @(posedge clk);
         #1;
         chk_regs("rst_hold");
      end
      reset = 1'b1;
   endtask

   logic [14:0] t2_stream;

   initial begin
      // T1: reset with a toggling, then no match before the 4th sample
      apply_reset(4);
      bit_in(1); bit_in(0); bit_in(1);
      chk("t1_cnt_early", match_cnt, 0);
      bit_in(0);
      chk("t1_cnt", match_cnt, 1);

      // T2: overlapping 1010, hits on bits 5 and 7
      apply_reset(1);
      t2_stream = 15'b110101011101111;
      for (int i = 14; i >= 0; i--) bit_in(t2_stream[i]);
      chk("t2_cnt", match_cnt, 2);

      // T3: non-overlapping, single hit on bit 5
      cycle(1'b0, 1'b1, 1'b1, 4'b1010, 1'b0, 1'b1);
      for (int i = 14; i >= 0; i--) bit_in(t2_stream[i]);
      chk("t3_cnt", match_cnt, 1);

      // T4: en gaps hold history
      cycle(1'b0, 1'b0, 1'b1, 4'b1010, 1'b1, 1'b1);
      bit_in(1); bit_in(0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
      bit_in(1); bit_in(0);
      chk("t4_cnt", match_cnt, 1);

      // T5: saturation on the 2-bit counter, clear beats a coincident hit
      cycle(1'b0, 1'b0, 1'b1, 4'b1111, 1'b1, 1'b1);
      for (int i = 0; i < 8; i++) bit_in(1);
      chk("t5_cnt2", match_cnt2, 3);
      chk("t5_sat2", cnt_sat2, 1);
      chk("t5_cnt",  match_cnt, 5);
      cycle(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b1);
      chk("t5_clr_cnt2", match_cnt2, 0);
      chk("t5_clr_sat2", cnt_sat2, 0);

      // T6: async reset in the middle of a pattern
      cycle(1'b0, 1'b0, 1'b1, 4'b1010, 1'b1, 1'b0);
      bit_in(1); bit_in(0); bit_in(1); bit_in(0); bit_in(1);
      en = 1'b1; a = 1'b0; cnt_clr = 1'b0; cfg_load = 1'b0;
      #1;
      chk("t6_pre_c", c, 1);
      apply_reset(1);
      bit_in(0); bit_in(1); bit_in(0);
      chk("t6_cnt", match_cnt, 0);

      // Randomised traffic
      for (int n = 0; n < 600; n++) begin
         int r;
         logic [SL-1:0] rp;
         r = $urandom_range(0, 199);
         rp = SL'($urandom);
         if (r == 0) begin
            apply_reset(1);
         end else if (r < 8) begin
            if (r == 1) rp = '0;
            if (r == 2) rp = '1;
            cycle($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b1, rp,
                  $urandom_range(0, 1) == 1, 1'b0);
         end else begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 1'b0, '0, 1'b0,
                  $urandom_range(0, 39) == 0);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
